adder_stream_stage: RTL
=======================

// Module: adder_stream_stage
// PURPOSE
//  Streaming wrapper around the combinational `adder`: accepts operand pairs over valid/ready,
//  adds them with an `adder` instance, and buffers {carry, sum} in a result FIFO drained
//  over valid/ready. Sits between the operand producer and the result consumer. Also restores
//  the carry-out that `adder` discards, and counts carry events.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=1)
//  DEPTH  4  result FIFO entries (power of 2, >=2)
// PORTS
//  clk_i          in   1                  clock, all state on rising edge
//  arst_ni        in   1                  asynchronous active-low reset
//  opa_i          in   WIDTH              operand A, qualified by in_valid_i
//  opb_i          in   WIDTH              operand B, qualified by in_valid_i
//  in_valid_i     in   1                  operand pair valid
//  in_ready_o     out  1                  stage can accept a pair this cycle
//  sum_o          out  WIDTH              FIFO head sum, qualified by out_valid_o
//  carry_o        out  1                  FIFO head carry-out, qualified by out_valid_o
//  out_valid_o    out  1                  FIFO non-empty
//  out_ready_i    in   1                  consumer takes head this cycle
//  count_o        out  $clog2(DEPTH+1)    entries held, 0..DEPTH
//  carry_cnt_o    out  16                 saturating count of accepted pairs with carry=1
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, count_o=0, carry_cnt_o=0,
//    out_valid_o=0, in_ready_o=1, sum_o/carry_o=0 (read-mux forced to 0 when empty).
//  - Push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i. Both are AXI-style:
//    producer holds opa_i/opb_i stable while valid & !ready; stage holds head stable likewise.
//  - in_ready_o = (count_o != DEPTH); registered-state only, no comb path from out_ready_i.
//    Full + pop in same cycle: in_ready_o still 0 that cycle (no pass-through).
//  - out_valid_o = (count_o != 0). Empty + push: no bypass; head visible next cycle.
//  - Latency: pair accepted at edge k -> out_valid_o=1 and sum_o/carry_o valid after edge k.
//  - Arithmetic: sum = (opa+opb) mod 2^WIDTH from `adder`; carry = (sum < opa), computed
//    at push and stored with sum, width WIDTH+1 per entry.
//  - Simultaneous push & pop (0<count<DEPTH): both pointers advance, count unchanged.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0; full/empty from count_o.
//  - carry_cnt_o += 1 on push with carry=1; saturates at 16'hFFFF, never wraps.
//  - Reset mid-operation: all buffered results dropped; no output pulse after release.
//  - Data ports outside valid handshakes are don't-care; X on them must not corrupt state.
// STRUCTURE
//  - Package adder_stream_pkg: DEF_WIDTH=8, DEF_DEPTH=4, CARRY_CNT_W=16 constants.
//  - Sub-module adder_res_fifo #(DW=WIDTH+1, DEPTH): flop-array sync FIFO, push/pop/
//    count/rdata, async active-low reset. Top = `adder` instance + carry logic + FIFO + counter.
//  - Assertions: no push when full, no pop when empty, count_o <= DEPTH, head stable while stalled.
// TESTING (WIDTH=8, DEPTH=4)
//  1. Push (3,4), out_ready_i=1 -> next cycle sum_o=7, carry_o=0, out_valid_o=1 one cycle.
//  2. Push (200,100) -> sum_o=44, carry_o=1, carry_cnt_o=1; (255,1) -> sum_o=0, carry_o=1.
//  3. out_ready_i=0, push 5 pairs back-to-back -> 4 accepted, in_ready_o=0 at count_o=4,
//     5th held; release out_ready_i -> results emerge in order, 5th accepted after first pop.
//  4. Random valid/ready toggling, 1000 pairs -> scoreboard order/values exact, no loss/dup.
//  5. Fill 3 entries, assert arst_ni low mid-stream -> count_o=0, out_valid_o=0, carry_cnt_o=0
//     immediately; after release first new push (1,1) returns sum_o=2.
//  6. Preload carry_cnt_o to 16'hFFFE via 2 carry pushes (force) -> stays 16'hFFFF.

Source files
------------

// File: rtl/adder_stream_pkg.sv
// Shared constants for the adder stream stage and its result FIFO.
package adder_stream_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int CARRY_CNT_W = 16;

endpackage

// File: rtl/adder.sv
// Plain combinational adder; the carry-out is intentionally not exposed,
// so callers that need it must reconstruct it from the truncated sum.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_res_fifo.sv
// Flop-array synchronous FIFO holding {carry, sum} results.
// Full/empty come from the occupancy count; pointers wrap naturally because
// DEPTH is a power of two. The read data is forced to zero while empty so the
// head outputs are clean after reset and between bursts.
module adder_res_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array is not reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adder_stream_stage.sv
// Streaming wrapper around the combinational adder: operand pairs come in over
// valid/ready, the sum plus a reconstructed carry-out is queued in a small FIFO,
// and results are drained over valid/ready. A saturating counter tracks how
// many accepted pairs produced a carry.
module adder_stream_stage
  import adder_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [WIDTH-1:0]           opa_i,
  input  logic [WIDTH-1:0]           opb_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WIDTH-1:0]           sum_o,
  output logic                       carry_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [CARRY_CNT_W-1:0]     carry_cnt_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0]       sum_w;
  logic                   carry_w;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WIDTH:0]         head;
  logic [CARRY_CNT_W-1:0] carry_cnt_q;

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (opa_i),
    .b   (opb_i),
    .sum (sum_w)
  );

  // The adder drops its carry; a wrapped sum is smaller than either operand.
  assign carry_w = (sum_w < opa_i);

  // Ready and valid depend only on registered occupancy, so a full stage
  // does not accept a new pair in the same cycle the consumer pops.
  assign in_ready_o  = !fifo_full;
  assign out_valid_o = !fifo_empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  adder_res_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (arst_ni),
    .push  (push),
    .wdata ({carry_w, sum_w}),
    .pop   (pop),
    .rdata (head),
    .count (count_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign carry_o = head[WIDTH];
  assign sum_o   = head[WIDTH-1:0];

  // Count accepted pairs that carried out, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      carry_cnt_q <= '0;
    end else if (push && carry_w && (carry_cnt_q != {CARRY_CNT_W{1'b1}})) begin
      carry_cnt_q <= carry_cnt_q + CARRY_CNT_W'(1);
    end
  end

  assign carry_cnt_o = carry_cnt_q;

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!arst_ni)
    (count_o == CW'(DEPTH)) |-> !push);

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!arst_ni)
    (count_o == '0) |-> !pop);

  a_count_bound : assert property (@(posedge clk_i) disable iff (!arst_ni)
    count_o <= CW'(DEPTH));

  a_head_stable : assert property (@(posedge clk_i) disable iff (!arst_ni)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable({carry_o, sum_o})));

endmodule
